// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b word and cache-line types.
package lc3b_types;
  localparam int WORD_W = 16;
  localparam int LINE_W = 128;
  typedef logic [WORD_W-1:0] lc3b_word;
  typedef logic [LINE_W-1:0] lc3b_line;
endpackage

// File: rtl/pmem_arb_select.sv
// pmem_arb_select: grant decision for the idle arbiter, owns last_grant.
// ARB_ROUND_ROBIN_EN alternates simultaneous grants; otherwise D always wins.
module pmem_arb_select (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic i_req,
  input  logic d_req,
  output logic start,
  output logic grant_d
);
  logic last_grant;
  assign start = i_req | d_req;
`ifdef ARB_ROUND_ROBIN_EN
  assign grant_d = d_req & (~i_req | ~last_grant);
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign grant_d = d_req;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) last_grant <= 1'b0;
    else if (idle && start) last_grant <= grant_d;
endmodule

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: grants one of the I/D caches to physical memory at a time.
// Build option ARB_ROUND_ROBIN_EN selects round-robin on simultaneous requests.
module pmem_arbiter
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     icache_pmem_read,
  input  lc3b_word icache_pmem_address,
  output lc3b_line icache_pmem_rdata,
  output logic     icache_pmem_resp,
  input  logic     dcache_pmem_read,
  input  logic     dcache_pmem_write,
  input  lc3b_word dcache_pmem_address,
  input  lc3b_line dcache_pmem_wdata,
  output lc3b_line dcache_pmem_rdata,
  output logic     dcache_pmem_resp,
  output logic     pmem_read,
  output logic     pmem_write,
  output lc3b_word pmem_address,
  output lc3b_line pmem_wdata,
  input  lc3b_line pmem_rdata,
  input  logic     pmem_resp
);
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
  state_t state, next_state;
  logic start, grant_d, serve_i, serve_d;
  pmem_arb_select u_sel (
    .clk     (clk),
    .rst     (rst),
    .idle    (state == IDLE),
    .i_req   (icache_pmem_read),
    .d_req   (dcache_pmem_read | dcache_pmem_write),
    .start   (start),
    .grant_d (grant_d)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next_state;
  always_comb begin
    serve_i = state == SERVE_I;
    serve_d = state == SERVE_D;
    next_state = state == IDLE ? (start ? (grant_d ? SERVE_D : SERVE_I) : IDLE)
               : pmem_resp ? IDLE : state;
    // a simultaneous D read+write forwards only the write
    pmem_read = serve_i ? icache_pmem_read : serve_d & dcache_pmem_read & ~dcache_pmem_write;
    pmem_write = serve_d & dcache_pmem_write;
    pmem_address = serve_i ? icache_pmem_address : serve_d ? dcache_pmem_address : '0;
    pmem_wdata = serve_d ? dcache_pmem_wdata : '0;
    icache_pmem_resp = serve_i & pmem_resp;
    dcache_pmem_resp = serve_d & pmem_resp;
    icache_pmem_rdata = serve_i ? pmem_rdata : '0;
    dcache_pmem_rdata = serve_d ? pmem_rdata : '0;
  end
endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter: directed checks of the pmem arbiter grant/forwarding behaviour.
module tb_pmem_arbiter;
  import lc3b_types::*;
  logic clk = 0, rst = 1;
  logic icache_pmem_read = 0, icache_pmem_resp;
  lc3b_word icache_pmem_address = '0;
  lc3b_line icache_pmem_rdata;
  logic dcache_pmem_read = 0, dcache_pmem_write = 0, dcache_pmem_resp;
  lc3b_word dcache_pmem_address = '0;
  lc3b_line dcache_pmem_wdata = '0, dcache_pmem_rdata;
  logic pmem_read, pmem_write, pmem_resp = 0;
  lc3b_word pmem_address;
  lc3b_line pmem_wdata, pmem_rdata = '0;
  int total = 0, bad = 0;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam lc3b_line L1 = 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff;
  localparam lc3b_line W1 = 128'hdead_beef_dead_beef_cafe_f00d_0123_4567;

  pmem_arbiter dut (
    .clk(clk), .rst(rst),
    .icache_pmem_read(icache_pmem_read), .icache_pmem_address(icache_pmem_address),
    .icache_pmem_rdata(icache_pmem_rdata), .icache_pmem_resp(icache_pmem_resp),
    .dcache_pmem_read(dcache_pmem_read), .dcache_pmem_write(dcache_pmem_write),
    .dcache_pmem_address(dcache_pmem_address), .dcache_pmem_wdata(dcache_pmem_wdata),
    .dcache_pmem_rdata(dcache_pmem_rdata), .dcache_pmem_resp(dcache_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #3;
    chk("rst_read", pmem_read, 0);
    chk("rst_write", pmem_write, 0);
    chk("rst_addr", pmem_address, 0);
    chk("rst_iresp", icache_pmem_resp, 0);
    tick(); rst = 0;
    tick(); icache_pmem_read = 1; icache_pmem_address = 16'h1230; #1;
    chk("i_idle_read", pmem_read, 0);
    tick(); #1;
    chk("i_read", pmem_read, 1);
    chk("i_addr", pmem_address, 16'h1230);
    chk("i_write0", pmem_write, 0);
    chk("i_wdata0", pmem_wdata, 0);
    chk("i_noresp", icache_pmem_resp, 0);
    tick(); #1;
    chk("i_hold", pmem_read, 1);
    tick(); pmem_resp = 1; pmem_rdata = L1; #1;
    chk("i_resp", icache_pmem_resp, 1);
    chk("i_rdata", icache_pmem_rdata, L1);
    chk("i_dresp0", dcache_pmem_resp, 0);
    tick(); pmem_resp = 0; icache_pmem_read = 0; #1;
    chk("i_back_idle", pmem_read, 0);
    chk("i_resp_once", icache_pmem_resp, 0);
    tick(); dcache_pmem_read = 1; dcache_pmem_write = 1;
    dcache_pmem_address = 16'h4440; dcache_pmem_wdata = W1; #1;
    chk("d_idle_write", pmem_write, 0);
    tick(); #1;
    chk("d_write", pmem_write, 1);
    chk("d_rw_read0", pmem_read, 0);
    chk("d_addr", pmem_address, 16'h4440);
    chk("d_wdata", pmem_wdata, W1);
    tick(); pmem_resp = 1; #1;
    chk("d_resp", dcache_pmem_resp, 1);
    chk("d_iresp0", icache_pmem_resp, 0);
    tick(); pmem_resp = 0; dcache_pmem_read = 0; dcache_pmem_write = 0; #1;
    chk("d_resp_once", dcache_pmem_resp, 0);
    chk("d_idle", pmem_write, 0);
    rst = 1;
    tick(); rst = 0;
    tick(); icache_pmem_read = 1; icache_pmem_address = 16'h1230;
    dcache_pmem_read = 1; dcache_pmem_address = 16'h5550; #1;
    chk("both_idle", pmem_read, 0);
    tick(); #1;
    chk("both_first_d", pmem_address, 16'h5550);
    tick(); pmem_resp = 1; #1;
    chk("both_dresp", dcache_pmem_resp, 1);
    chk("both_iresp0", icache_pmem_resp, 0);
    tick(); pmem_resp = 0; #1;
    chk("both_gap", pmem_read, 0);
    tick(); #1;
    chk("both_second", pmem_address, RR ? 16'h1230 : 16'h5550);
    tick(); pmem_resp = 1; #1;
    chk("both_second_iresp", icache_pmem_resp, RR ? 1'b1 : 1'b0);
    tick(); pmem_resp = 0; icache_pmem_read = 0; dcache_pmem_read = 0;
    tick(); dcache_pmem_read = 1; dcache_pmem_address = 16'h6660;
    tick(); #1;
    chk("dbusy_addr", pmem_address, 16'h6660);
    tick(); icache_pmem_read = 1; icache_pmem_address = 16'h1230; #1;
    chk("dbusy_keep", pmem_address, 16'h6660);
    chk("dbusy_iresp0", icache_pmem_resp, 0);
    tick(); pmem_resp = 1; #1;
    chk("dbusy_dresp", dcache_pmem_resp, 1);
    tick(); pmem_resp = 0; dcache_pmem_read = 0; #1;
    chk("dbusy_gap", pmem_read, 0);
    tick(); #1;
    chk("dbusy_i_addr", pmem_address, 16'h1230);
    chk("dbusy_i_read", pmem_read, 1);
    tick(); icache_pmem_read = 0; #1;
    chk("drop_read0", pmem_read, 0);
    chk("drop_addr", pmem_address, 16'h1230);
    tick(); pmem_resp = 1; #1;
    chk("drop_iresp", icache_pmem_resp, 1);
    tick(); pmem_resp = 0; icache_pmem_read = 1; icache_pmem_address = 16'h7770;
    tick(); #1;
    chk("rmid_read", pmem_read, 1);
    #2; rst = 1; pmem_resp = 1; #1;
    chk("rmid_read0", pmem_read, 0);
    chk("rmid_addr0", pmem_address, 0);
    chk("rmid_iresp0", icache_pmem_resp, 0);
    tick(); rst = 0; pmem_resp = 0; dcache_pmem_read = 1; dcache_pmem_address = 16'h8880; #1;
    chk("rmid_idle", pmem_read, 0);
    tick(); #1;
    chk("rmid_grant_d", pmem_address, 16'h8880);
    tick(); pmem_resp = 1;
    tick(); pmem_resp = 0; icache_pmem_read = 0; dcache_pmem_read = 0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pmem_arbiter.md
PMEM_ARBITER -- requirements
Module: pmem_arbiter

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports icache_pmem_read  input  1  I-side line read request, held until icache_pmem_resp.
REQ-004 SHALL have port icache_pmem_address  input  lc3b_word  I-side line address.
REQ-005 SHALL have ports icache_pmem_rdata  output  lc3b_line  and icache_pmem_resp  output  1  (I-side return data and one-cycle completion).
REQ-006 SHALL have ports dcache_pmem_read  input  1  and dcache_pmem_write  input  1  (D-side requests, held until dcache_pmem_resp).
REQ-007 SHALL have ports dcache_pmem_address  input  lc3b_word  and dcache_pmem_wdata  input  lc3b_line.
REQ-008 SHALL have ports dcache_pmem_rdata  output  lc3b_line  and dcache_pmem_resp  output  1.
REQ-009 SHALL have ports pmem_read  output  1,  pmem_write  output  1,  pmem_address  output  lc3b_word,  pmem_wdata  output  lc3b_line  (downstream request).
REQ-010 SHALL have ports pmem_rdata  input  lc3b_line  and pmem_resp  input  1  (downstream completion, one cycle per transaction).

Function
REQ-011 SHALL implement FSM states IDLE, SERVE_I, SERVE_D; at most one requester granted at any time.
REQ-012 IDLE: all pmem_* strobes and both *_resp low; next state chosen from requests sampled this cycle.
REQ-013 IDLE with only I request -> SERVE_I; only D request (read or write) -> SERVE_D; none -> IDLE.
REQ-014 IDLE with both requesting -> arbitration per REQ-023/REQ-024.
REQ-015 SERVE_X: pmem_read/pmem_write/pmem_address/pmem_wdata SHALL combinationally mirror the granted requester's inputs; I side drives pmem_write=0, pmem_wdata=0.
REQ-016 SERVE_X: X_pmem_resp = pmem_resp and X_pmem_rdata = pmem_rdata in the same cycle; non-granted resp held 0; both rdata outputs may carry pmem_rdata.
REQ-017 SERVE_X with pmem_resp=1 -> IDLE next cycle; otherwise stay; grant never changes mid-transaction.
REQ-018 Latency: request visible in IDLE at cycle N -> pmem strobe asserted at cycle N+1; mandatory one IDLE cycle between consecutive grants.
REQ-019 D side asserting read and write together: write forwarded, read ignored.
REQ-020 Requester dropping its request while granted (protocol violation): arbiter SHALL remain in SERVE_X until pmem_resp, forwarding deasserted strobes.
REQ-021 A 1-bit last_grant register (0=I, 1=D) SHALL update on every IDLE->SERVE transition.

Reset
REQ-022 rst (any time, including mid-transaction) SHALL force state=IDLE, last_grant=0 immediately; all outputs 0 while rst high; in-flight transaction abandoned, no resp issued.

Configuration
REQ-023 With ARB_ROUND_ROBIN_EN defined: on simultaneous requests, grant side opposite last_grant (after reset, D first).
REQ-024 Without ARB_ROUND_ROBIN_EN: simultaneous requests always grant D; last_grant still maintained but unused.

Structure
REQ-025 lc3b_word and lc3b_line SHALL come from shared package lc3b_types; the FSM state enum SHALL be local to the module.
REQ-026 Grant decision (IDLE next-state choice incl. last_grant) SHALL be sub-module pmem_arb_select; rest in pmem_arbiter.

Verification
REQ-027 I read 0x1230 alone, pmem_resp after 3 cycles -> pmem_read=1, pmem_address=0x1230 from N+1; icache_pmem_resp=1 with line data in resp cycle; IDLE next.
REQ-028 D write 0x4440, wdata 0xDEADBEEF... -> pmem_write=1, pmem_wdata matches; dcache_pmem_resp pulses once; icache_pmem_resp stays 0.
REQ-029 I and D request same cycle after reset, both held -> D served first, then one IDLE cycle, then I (RR on); D served repeatedly while D re-requests (RR off).
REQ-030 I request arrives while SERVE_D active -> no pmem_address change until D resp; I granted after intervening IDLE.
REQ-031 rst pulsed mid SERVE_I before pmem_resp -> outputs 0 immediately, no icache_pmem_resp, state IDLE; next simultaneous request grants D.
